// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: multi-account ATM session controller.
// Card/account validation, PIN check with per-account lockout, and a menu of
// balance, withdraw, deposit, transfer, PIN change and exit operations over an
// internal balance/PIN/lock table.
// Optional feature macro: ATM_SESSION_LIMIT_EN adds a cumulative per-session
// cap (SESSION_LIMIT) on successful withdraw and transfer amounts.
module atm_session_ctrl #(
  parameter int unsigned       NUM_ACCOUNTS   = 4,
  parameter int unsigned       ACC_BASE       = 2176,
  parameter int unsigned       ACC_W          = 12,
  parameter int unsigned       PIN_W          = 4,
  parameter int unsigned       BAL_W          = 16,
  parameter int unsigned       INIT_BALANCE   = 20000,
  parameter logic [PIN_W-1:0]  INIT_PIN       = 4'b0100,
  parameter int unsigned       MAX_PIN_TRIES  = 3,
  parameter int unsigned       WITHDRAW_LIMIT = 10000,
  parameter int unsigned       SESSION_LIMIT  = 15000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_valid,
  input  logic [ACC_W-1:0] acc_number,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [BAL_W-1:0] amount,
  input  logic [ACC_W-1:0] dest_acc,
  input  logic [PIN_W-1:0] new_pin,
  input  logic             exit,
  output logic             done,
  output logic             error,
  output logic [3:0]       err_code,
  output logic [BAL_W-1:0] balance,
  output logic [1:0]       state
);

  localparam int unsigned IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int unsigned TRY_W = $clog2(MAX_PIN_TRIES + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GET_PIN = 2'd1, ST_MENU = 2'd2} state_t;
  typedef enum logic [3:0] {
    ERR_OK = 4'd0, ERR_BAD_ACC, ERR_BAD_PIN, ERR_LOCKED, ERR_INSUFF,
    ERR_LIMIT, ERR_BAD_DEST, ERR_OVERFLOW, ERR_BAD_OP
  } err_t;
  typedef enum logic [2:0] {
    OP_BALANCE = 3'd0, OP_WITHDRAW, OP_DEPOSIT, OP_TRANSFER, OP_CHANGE_PIN, OP_EXIT
  } op_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [TRY_W-1:0]   r_tries, w_tries_nxt, w_tries_inc;
  logic               r_card_d;
  logic [BAL_W-1:0]   r_bal [NUM_ACCOUNTS];
  logic [PIN_W-1:0]   r_pin [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] r_lock;
  logic               r_done, r_error, w_done_nxt, w_error_nxt;
  err_t               r_code, w_code_nxt;
  logic [BAL_W-1:0]   r_balance, w_bal_out_nxt;

  logic [ACC_W-1:0]   w_acc_off, w_dest_off;
  logic               w_acc_ok, w_dest_ok;
  logic [IDX_W-1:0]   w_acc_idx, w_dest_idx;
  logic [BAL_W-1:0]   w_own, w_dest_bal, w_own_val;
  logic [BAL_W:0]     w_dep_sum, w_dest_sum;
  logic               w_over_lim, w_short, w_sess_over;
  logic               w_own_we, w_dest_we, w_pin_we, w_lock_set;

  assign w_acc_off   = acc_number - ACC_W'(ACC_BASE);
  assign w_acc_ok    = (acc_number >= ACC_W'(ACC_BASE)) && (w_acc_off < ACC_W'(NUM_ACCOUNTS));
  assign w_acc_idx   = w_acc_off[IDX_W-1:0];
  assign w_dest_off  = dest_acc - ACC_W'(ACC_BASE);
  assign w_dest_idx  = w_dest_off[IDX_W-1:0];
  assign w_dest_ok   = (dest_acc >= ACC_W'(ACC_BASE)) && (w_dest_off < ACC_W'(NUM_ACCOUNTS)) &&
                       (w_dest_idx != r_idx);
  assign w_own       = r_bal[r_idx];
  assign w_dest_bal  = r_bal[w_dest_idx];
  assign w_dep_sum   = {1'b0, w_own} + {1'b0, amount};
  assign w_dest_sum  = {1'b0, w_dest_bal} + {1'b0, amount};
  assign w_over_lim  = amount > BAL_W'(WITHDRAW_LIMIT);
  assign w_short     = amount > w_own;
  assign w_tries_inc = r_tries + TRY_W'(1);

`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W-1:0] r_sess;
  logic [BAL_W:0]   w_sess_sum;
  logic             w_sess_clr, w_sess_add;
  assign w_sess_sum  = {1'b0, r_sess} + {1'b0, amount};
  assign w_sess_over = w_sess_sum > (BAL_W+1)'(SESSION_LIMIT);
`else
  assign w_sess_over = 1'b0;
`endif

  // Next-state, result and table-write decode for the session FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_tries_nxt   = r_tries;
    w_done_nxt    = 1'b0;
    w_code_nxt    = r_code;
    w_error_nxt   = r_error;
    w_bal_out_nxt = r_balance;
    w_own_we      = 1'b0;
    w_own_val     = w_own;
    w_dest_we     = 1'b0;
    w_pin_we      = 1'b0;
    w_lock_set    = 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
    w_sess_clr    = 1'b0;
    w_sess_add    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // evaluate only on card insertion (rising card_valid)
        if (card_valid && !r_card_d) begin
          if (!w_acc_ok) begin
            w_done_nxt = 1'b1;
            w_code_nxt = ERR_BAD_ACC;
          end else if (r_lock[w_acc_idx]) begin
            w_done_nxt = 1'b1;
            w_code_nxt = ERR_LOCKED;
          end else begin
            w_idx_nxt   = w_acc_idx;
            w_tries_nxt = '0;
            w_state_nxt = ST_GET_PIN;
          end
        end
      end
      ST_GET_PIN: begin
        if (exit || !card_valid) begin
          w_state_nxt   = ST_IDLE;
          w_bal_out_nxt = '0;
        end else if (pin_valid) begin
          w_done_nxt = 1'b1;
          if (pin == r_pin[r_idx]) begin
            w_code_nxt    = ERR_OK;
            w_bal_out_nxt = w_own;
            w_state_nxt   = ST_MENU;
`ifdef ATM_SESSION_LIMIT_EN
            w_sess_clr    = 1'b1;
`endif
          end else begin
            w_tries_nxt = w_tries_inc;
            if (w_tries_inc == TRY_W'(MAX_PIN_TRIES)) begin
              w_code_nxt  = ERR_LOCKED;
              w_lock_set  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_code_nxt  = ERR_BAD_PIN;
            end
          end
        end
      end
      ST_MENU: begin
        if (exit || !card_valid) begin
          w_state_nxt   = ST_IDLE;
          w_bal_out_nxt = '0;
        end else if (req) begin
          w_done_nxt    = 1'b1;
          w_code_nxt    = ERR_OK;
          w_bal_out_nxt = w_own;
          case (op)
            OP_BALANCE: ;
            OP_WITHDRAW, OP_TRANSFER: begin
              if (op == OP_TRANSFER && !w_dest_ok)            w_code_nxt = ERR_BAD_DEST;
              else if (w_over_lim || w_sess_over)              w_code_nxt = ERR_LIMIT;
              else if (w_short)                                w_code_nxt = ERR_INSUFF;
              else if (op == OP_TRANSFER && w_dest_sum[BAL_W]) w_code_nxt = ERR_OVERFLOW;
              else begin
                w_own_we      = 1'b1;
                w_own_val     = w_own - amount;
                w_bal_out_nxt = w_own - amount;
                w_dest_we     = (op == OP_TRANSFER);
`ifdef ATM_SESSION_LIMIT_EN
                w_sess_add    = 1'b1;
`endif
              end
            end
            OP_DEPOSIT: begin
              if (w_dep_sum[BAL_W]) w_code_nxt = ERR_OVERFLOW;
              else begin
                w_own_we      = 1'b1;
                w_own_val     = w_dep_sum[BAL_W-1:0];
                w_bal_out_nxt = w_dep_sum[BAL_W-1:0];
              end
            end
            OP_CHANGE_PIN: w_pin_we = 1'b1;
            OP_EXIT: begin
              w_state_nxt   = ST_IDLE;
              w_bal_out_nxt = '0;
            end
            default: w_code_nxt = ERR_BAD_OP;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_done_nxt) w_error_nxt = (w_code_nxt != ERR_OK);
  end

  // State, account table and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_tries   <= '0;
      r_card_d  <= 1'b0;
      r_lock    <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= ERR_OK;
      r_balance <= '0;
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        r_bal[i] <= BAL_W'(INIT_BALANCE);
        r_pin[i] <= INIT_PIN;
      end
`ifdef ATM_SESSION_LIMIT_EN
      r_sess    <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_tries   <= w_tries_nxt;
      r_card_d  <= card_valid;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_code    <= w_code_nxt;
      r_balance <= w_bal_out_nxt;
      if (w_own_we)   r_bal[r_idx]      <= w_own_val;
      if (w_dest_we)  r_bal[w_dest_idx] <= w_dest_sum[BAL_W-1:0];
      if (w_pin_we)   r_pin[r_idx]      <= new_pin;
      if (w_lock_set) r_lock[r_idx]     <= 1'b1;
`ifdef ATM_SESSION_LIMIT_EN
      if (w_sess_clr)      r_sess <= '0;
      else if (w_sess_add) r_sess <= w_sess_sum[BAL_W-1:0];
`endif
    end
  end

  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_code;
  assign balance  = r_balance;
  assign state    = r_state;

endmodule
